// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the 9-bit core fetch path.
// Holds the sequencer state type, the default geometry and the opcode map.
// No logic; imported by every fetch_sequencer file.
package fetch_sequencer_pkg;

    // Default geometry of the fetch path
    localparam int PC_W_DEF       = 10;
    localparam int START_ADDR_DEF = 0;
    localparam int CNT_W_DEF      = 16;

    // Sequencer states; instr_valid is decoded from ST_RUN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // 9-bit instruction: op[8:6], fn[5:3], operand[2:0]
    localparam int OP_W = 3;
    localparam int FN_W = 3;

    localparam logic [OP_W-1:0] opALU    = 3'b000;
    localparam logic [OP_W-1:0] opLOAD   = 3'b001;
    localparam logic [OP_W-1:0] opSTORE  = 3'b010;
    localparam logic [OP_W-1:0] opMOV    = 3'b011;
    localparam logic [OP_W-1:0] opCMP    = 3'b100;
    localparam logic [OP_W-1:0] opBRANCH = 3'b101;
    localparam logic [OP_W-1:0] opIMM    = 3'b110;
    localparam logic [OP_W-1:0] opHALT   = 3'b111;

    localparam logic [FN_W-1:0] fnADD = 3'b000;
    localparam logic [FN_W-1:0] fnSUB = 3'b001;
    localparam logic [FN_W-1:0] fnAND = 3'b010;
    localparam logic [FN_W-1:0] fnOR  = 3'b011;
    localparam logic [FN_W-1:0] fnXOR = 3'b100;
    localparam logic [FN_W-1:0] fnSHL = 3'b101;
    localparam logic [FN_W-1:0] fnSHR = 3'b110;
    localparam logic [FN_W-1:0] fnNOT = 3'b111;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundles the sequencer's control, decode-strobe and status signals.
// master = testbench/core side driving Start and decode strobes; slave = sequencer.
// No storage; pure wiring.
interface fetch_sequencer_if
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    // Requests and decode strobes into the sequencer
    logic              Start;
    logic              halt_req;
    logic              branch_en;
    logic [PC_W-1:0]   target;
    logic              flag_write;
    logic              flag_d;
    logic              overflow_write;
    logic              overflow_d;

    // Sequencer outputs
    logic [PC_W-1:0]   PC;
    logic              FLAG;
    logic              OVERFLOW;
    logic              instr_valid;
    logic              Done;
    logic [CNT_W-1:0]  instr_count;

    modport master (
        output Start, halt_req, branch_en, target,
               flag_write, flag_d, overflow_write, overflow_d,
        input  PC, FLAG, OVERFLOW, instr_valid, Done, instr_count
    );

    modport slave (
        input  Start, halt_req, branch_en, target,
               flag_write, flag_d, overflow_write, overflow_d,
        output PC, FLAG, OVERFLOW, instr_valid, Done, instr_count
    );

endinterface

// File: rtl/fetch_sequencer_status_reg.sv
// FLAG and OVERFLOW status registers written by the executing instruction.
// Latency: a write in cycle N is visible from cycle N+1; there is no bypass.
// Writes are accepted only while an instruction is valid; clear wins on program start.
module fetch_sequencer_status_reg (
    input  logic Clk,
    input  logic Reset,
    input  logic instr_valid_i,
    input  logic clear_i,
    input  logic flag_write_i,
    input  logic flag_d_i,
    input  logic overflow_write_i,
    input  logic overflow_d_i,
    output logic flag_o,
    output logic overflow_o
);

    logic flag_q, flag_d;
    logic ovf_q, ovf_d;

    // Next value: clear on run start, otherwise gated writes, otherwise hold
    always_comb begin
        flag_d = flag_q;
        ovf_d  = ovf_q;
        if (clear_i) begin
            flag_d = 1'b0;
            ovf_d  = 1'b0;
        end else if (instr_valid_i) begin
            if (flag_write_i) begin
                flag_d = flag_d_i;
            end
            if (overflow_write_i) begin
                ovf_d = overflow_d_i;
            end
        end
    end

    // Status storage with asynchronous reset
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            flag_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            flag_q <= flag_d;
            ovf_q  <= ovf_d;
        end
    end

    assign flag_o     = flag_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and run/halt sequencer for the 9-bit core.
// Latency: Start to first instr_valid is one cycle; one instruction retires per RUN cycle.
// Start is a level; after HALTED it must drop low before another run can begin.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int START_ADDR = START_ADDR_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    fetch_sequencer_if.slave  bus
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_start;
    logic              instr_valid;

    assign instr_valid = (state_q == ST_RUN);

    // Next state, next PC, Done and retire counter
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        done_d    = done_q;
        cnt_d     = cnt_q;
        run_start = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    state_d   = ST_RUN;
                    pc_d      = START_PC;
                    cnt_d     = '0;
                    run_start = 1'b1;
                end
            end
            ST_RUN: begin
                // Counter saturates so a runaway program never wraps it
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (bus.halt_req) begin
                    state_d = ST_HALTED;
                    done_d  = 1'b1;
                end else if (bus.branch_en) begin
                    pc_d = bus.target;
                end else begin
                    // Natural overflow wraps the top address to zero
                    pc_d = pc_q + PC_W'(1);
                end
            end
            ST_HALTED: begin
                if (!bus.Start) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
            end
        endcase
    end

    // Sequencer registers with asynchronous reset
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= START_PC;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    fetch_sequencer_status_reg u_status (
        .Clk              (Clk),
        .Reset            (Reset),
        .instr_valid_i    (instr_valid),
        .clear_i          (run_start),
        .flag_write_i     (bus.flag_write),
        .flag_d_i         (bus.flag_d),
        .overflow_write_i (bus.overflow_write),
        .overflow_d_i     (bus.overflow_d),
        .flag_o           (bus.FLAG),
        .overflow_o       (bus.OVERFLOW)
    );

    assign bus.PC          = pc_q;
    assign bus.Done        = done_q;
    assign bus.instr_count = cnt_q;
    assign bus.instr_valid = instr_valid;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random traffic.
// Expected values come from a run/done/pc/count model kept in plain integers.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_fetch_sequencer;

    localparam int PC_W   = 10;
    localparam int CNT_W  = 16;
    localparam int START  = 0;
    localparam int PC_MOD = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int VEC_W  = PC_W + 4 + CNT_W;

    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   failures = 0;

    fetch_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    fetch_sequencer #(.PC_W(PC_W), .START_ADDR(START), .CNT_W(CNT_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Reference model: running / done flags, PC and count as integers
    bit m_run, m_done, m_flag, m_ovf;
    int m_pc, m_cnt;

    task automatic model_reset();
        m_run = 0; m_done = 0; m_flag = 0; m_ovf = 0;
        m_pc = START; m_cnt = 0;
    endtask

    // One clock edge of the model, using the inputs currently applied
    task automatic model_step();
        if (m_run) begin
            if (bus.flag_write)     m_flag = bus.flag_d;
            if (bus.overflow_write) m_ovf  = bus.overflow_d;
            m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            if (bus.halt_req) begin
                m_run = 0; m_done = 1;
            end else if (bus.branch_en) begin
                m_pc = int'(bus.target);
            end else begin
                m_pc = (m_pc + 1) % PC_MOD;
            end
        end else if (m_done) begin
            if (!bus.Start) m_done = 0;
        end else if (bus.Start) begin
            m_run = 1; m_pc = START; m_flag = 0; m_ovf = 0; m_cnt = 0;
        end
    endtask

    function automatic logic [VEC_W-1:0] exp_vec();
        return {PC_W'(m_pc), m_flag, m_ovf, m_run, m_done, CNT_W'(m_cnt)};
    endfunction

    function automatic logic [VEC_W-1:0] obs_vec();
        return {bus.PC, bus.FLAG, bus.OVERFLOW, bus.instr_valid, bus.Done, bus.instr_count};
    endfunction

    task automatic drive(input bit st, input bit hr, input bit br, input int tgt,
                         input bit fw, input bit fd, input bit ow, input bit od);
        @(negedge Clk);
        bus.Start = st; bus.halt_req = hr; bus.branch_en = br; bus.target = PC_W'(tgt);
        bus.flag_write = fw; bus.flag_d = fd; bus.overflow_write = ow; bus.overflow_d = od;
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge Clk); #1;
        checks++;
        if (obs_vec() !== exp_vec() || bus.PC !== PC_W'(START)) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obs_vec(), exp_vec());
        end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_basic_run();
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        checks++;
        if (bus.PC !== 10'd0 || bus.instr_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL start_latency got=%h exp=%h", obs_vec(), exp_vec());
        end
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
            checks++;
            if (bus.PC !== PC_W'(i) || bus.instr_count !== CNT_W'(i) || obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL seq_pc%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
        checks++;
        if (bus.Done !== 1'b1 || bus.PC !== 10'd4 || bus.instr_count !== 16'd5 ||
            bus.instr_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL halt_basic got=%h exp=%h", obs_vec(), exp_vec());
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        checks++;
        if (bus.Done !== 1'b0 || bus.PC !== 10'd4 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL halted_to_idle got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_branch_halt();
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 'h3A, 0, 0, 0, 0); tick();
        checks++;
        if (bus.PC !== 10'h03A || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL branch_taken got=%h exp=%h", obs_vec(), exp_vec());
        end
        drive(0, 1, 1, 'h11, 0, 0, 0, 0); tick();
        checks++;
        if (bus.PC !== 10'h03A || bus.Done !== 1'b1 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL halt_over_branch got=%h exp=%h", obs_vec(), exp_vec());
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_wrap();
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 1, PC_MOD - 1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        checks++;
        if (bus.PC !== 10'd0 || bus.instr_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL pc_wrap got=%h exp=%h", obs_vec(), exp_vec());
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        checks++;
        if (bus.PC !== 10'd1 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL pc_after_wrap got=%h exp=%h", obs_vec(), exp_vec());
        end
        drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_status();
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 1, 0, 0); tick();
        checks++;
        if (bus.FLAG !== 1'b1 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL flag_write got=%h exp=%h", obs_vec(), exp_vec());
        end
        drive(0, 0, 0, 0, 1, 0, 1, 1); tick();
        checks++;
        if (bus.FLAG !== 1'b0 || bus.OVERFLOW !== 1'b1 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL dual_write got=%h exp=%h", obs_vec(), exp_vec());
        end
        drive(0, 1, 0, 0, 1, 1, 1, 0); tick();
        checks++;
        if (bus.FLAG !== 1'b1 || bus.OVERFLOW !== 1'b0 || bus.Done !== 1'b1 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL write_with_halt got=%h exp=%h", obs_vec(), exp_vec());
        end
        drive(1, 0, 1, 'h155, 1, 0, 1, 1); tick();
        checks++;
        if (bus.FLAG !== 1'b1 || bus.OVERFLOW !== 1'b0 || bus.Done !== 1'b1 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL halted_writes_ignored got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_restart();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
            checks++;
            if (bus.Done !== 1'b1 || bus.instr_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL start_held_halted%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        checks++;
        if (bus.Done !== 1'b0 || bus.FLAG !== 1'b1 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL back_to_idle got=%h exp=%h", obs_vec(), exp_vec());
        end
        drive(0, 0, 1, 'h20, 1, 0, 1, 1); tick();
        checks++;
        if (bus.FLAG !== 1'b1 || bus.OVERFLOW !== 1'b0 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL idle_hold got=%h exp=%h", obs_vec(), exp_vec());
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        checks++;
        if (bus.PC !== PC_W'(START) || bus.instr_count !== 16'd0 || bus.FLAG !== 1'b0 ||
            bus.instr_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL restart got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_mid_reset();
        drive(0, 0, 0, 0, 1, 1, 0, 0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        end
        checks++;
        if (bus.PC !== 10'h005 || bus.FLAG !== 1'b1 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL pre_reset_state got=%h exp=%h", obs_vec(), exp_vec());
        end
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (bus.PC !== 10'd0 || bus.FLAG !== 1'b0 || bus.OVERFLOW !== 1'b0 ||
            bus.Done !== 1'b0 || bus.instr_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", obs_vec(), exp_vec());
        end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) == 0), int'($urandom_range(0, PC_MOD - 1)),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_cycle%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_branch_halt();
        test_wrap();
        test_status();
        test_restart();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences instruction fetch for the 9-bit core.
- Owns the program counter, the branch-condition FLAG register and the OVERFLOW status register.
- Consumes the combinational decode strobes (branch_en, flag_write, overflow_write) plus datapath results, and drives the instruction ROM address.
- Controls program start, halt and restart. Sits between the top-level testbench handshake (Start/Done) and instruction ROM + decoder.

Parameters:
- PC_W, 10, program counter width; address space is 2**PC_W words.
- START_ADDR, 0, PC value loaded on each program start.
- CNT_W, 16, width of the executed-instruction counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  level request to begin a program run.
- halt_req  in  1  current instruction is HALT (from decoder).
- branch_en  in  1  take branch this cycle (from decoder).
- target  in  PC_W  absolute branch target (from target LUT).
- flag_write  in  1  load FLAG this cycle.
- flag_d  in  1  compare result from ALU.
- overflow_write  in  1  load OVERFLOW this cycle.
- overflow_d  in  1  carry/overflow result from ALU.
- PC  out  PC_W  instruction ROM address.
- FLAG  out  1  registered branch-condition flag; fed back to the decoder.
- OVERFLOW  out  1  registered overflow status.
- instr_valid  out  1  high while the instruction at PC executes (state RUN).
- Done  out  1  program has halted.
- instr_count  out  CNT_W  instructions retired in the current run.

Behaviour:
- Reset (async, any state, mid-run included):
  - state=IDLE, PC=START_ADDR, FLAG=0, OVERFLOW=0, Done=0, instr_count=0.
  - instr_valid=0, since it is decoded from state.
- States: IDLE, RUN, HALTED. Encoding is in the package; instr_valid = (state==RUN).
- IDLE:
  - Start=1: next edge goes to RUN, PC=START_ADDR, FLAG=0, OVERFLOW=0, instr_count=0.
  - Start=0: all outputs hold.
- RUN, one instruction per cycle, with priority in this order:
  1. halt_req=1: go to HALTED; PC holds; Done=1 at the next edge; instr_count+1.
  2. Otherwise, branch_en=1: PC=target.
  3. Otherwise: PC=PC+1 modulo 2**PC_W, so the max address wraps to 0. No error is raised.
  - instr_count increments on every RUN cycle and saturates at all-ones.
- Status writes, accepted only when state==RUN:
  - flag_write=1: FLAG<=flag_d.
  - overflow_write=1: OVERFLOW<=overflow_d.
  - Both write strobes may be active in the same cycle, and both take effect.
  - A write in the same cycle as halt_req still takes effect, because the instruction completes.
  - In IDLE and HALTED, write strobes and branch_en are ignored.
- Branch timing: branch_en is combinational from the current FLAG value. A FLAG written in cycle N affects branches from cycle N+1 onward. There is no bypass.
- HALTED:
  - Done=1, PC, flags and count hold.
  - Start=0: next edge goes to IDLE and clears Done.
  - Start held high remains HALTED, so a run needs a fresh Start pulse after the low phase.
- Start is ignored while in RUN.
- All outputs are registered except instr_valid. Latency from Start=1 to first instr_valid=1 is 1 cycle.

Decomposition:
- definitions package gains:
  - state typedef (IDLE/RUN/HALTED).
  - PC_W, START_ADDR and CNT_W defaults as constants.
  - opHALT encoding, alongside the existing op/fn codes.
- One natural sub-module: status_reg, holding FLAG and OVERFLOW with write enables gated by instr_valid, plus async reset.
- PC/next-PC logic and the FSM stay in fetch_sequencer.

Test Plan:
- Reset mid-RUN (PC=0x05, FLAG=1) -> immediately PC=0, FLAG=0, OVERFLOW=0, Done=0, instr_valid=0.
- Start=1 in IDLE, no branches, 4 cycles -> PC 0,1,2,3,4; instr_count=4. Then halt_req -> Done=1 next edge, PC held at 4, count=5.
- RUN with branch_en=1 and target=0x3A, then halt_req=1 and branch_en=1 in the same cycle -> PC=0x3A, then halt wins and PC stays 0x3A.
- PC_W=4, PC=0xF, no branch -> PC=0x0 next cycle, still RUN.
- flag_write=1 and flag_d=1 in cycle N -> FLAG=1 from N+1. overflow_write with halt_req in the same cycle -> OVERFLOW updated and Done=1. Write strobes in HALTED -> no change.
- In HALTED with Start held 1 for 3 cycles -> stays HALTED. Start=0 -> IDLE, Done=0. Start=1 -> RUN, PC=START_ADDR, instr_count=0, FLAG=0.
